// File: rtl/muldiv_cdb_arbiter.sv
// MUL/DIV completion buffer: per-source result queues that feed one shared CDB slot in ROB age order.
// It also drives issue stalls that keep in-flight FU results from overflowing a queue, and squashes flushed entries.
module muldiv_cdb_arbiter #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mul_valid,
  input  logic [TAG_W-1:0] i_mul_tag,
  input  logic [XLEN-1:0]  i_mul_value,
  input  logic             i_div_valid,
  input  logic [TAG_W-1:0] i_div_tag,
  input  logic [XLEN-1:0]  i_div_value,
  output logic             o_mul_stall,
  output logic             o_div_stall,
  output logic             o_cdb_valid,
  output logic [TAG_W-1:0] o_cdb_tag,
  output logic [XLEN-1:0]  o_cdb_value,
  output logic             o_cdb_is_div,
  input  logic             i_cdb_grant,
  input  logic             i_flush,
  input  logic             i_flush_en,
  input  logic [TAG_W-1:0] i_flush_tag,
  input  logic [TAG_W-1:0] i_rob_head_tag,
  output logic             o_overflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  // Index 0 is the MUL queue, index 1 the DIV queue; entry 0 is always the head.
  logic [TAG_W-1:0] tag_q [2][DEPTH];
  logic [TAG_W-1:0] tag_d [2][DEPTH];
  logic [XLEN-1:0]  val_q [2][DEPTH];
  logic [XLEN-1:0]  val_d [2][DEPTH];
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic             ovf_q, ovf_set;

  logic             in_v   [2];
  logic [TAG_W-1:0] in_tag [2];
  logic [XLEN-1:0]  in_val [2];
  logic             pop    [2];
  logic             head_v [2];
  logic             sel_div;

  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] tag,
                                           input logic [TAG_W-1:0] head);
    logic [TAG_W:0] diff;
    diff = {1'b0, tag} - {1'b0, head};
    return diff[TAG_W-1:0];
  endfunction

  assign in_v[0]   = i_mul_valid;
  assign in_tag[0] = i_mul_tag;
  assign in_val[0] = i_mul_value;
  assign in_v[1]   = i_div_valid;
  assign in_tag[1] = i_div_tag;
  assign in_val[1] = i_div_value;

  assign head_v[0] = (cnt_q[0] != '0);
  assign head_v[1] = (cnt_q[1] != '0);

  // Equal ages cannot occur for distinct tags; MUL wins the tie regardless.
  assign sel_div = head_v[1] &&
                   (!head_v[0] ||
                    (age(tag_q[1][0], i_rob_head_tag) < age(tag_q[0][0], i_rob_head_tag)));

  assign o_cdb_valid  = head_v[0] || head_v[1];
  assign o_cdb_is_div = sel_div;
  assign o_cdb_tag    = !o_cdb_valid ? '0 : (sel_div ? tag_q[1][0] : tag_q[0][0]);
  assign o_cdb_value  = !o_cdb_valid ? '0 : (sel_div ? val_q[1][0] : val_q[0][0]);

  assign pop[0] = o_cdb_valid && i_cdb_grant && !sel_div;
  assign pop[1] = o_cdb_valid && i_cdb_grant && sel_div;

  assign o_mul_stall = (cnt_q[0] >= CW'(DEPTH - 1));
  assign o_div_stall = (cnt_q[1] >= CW'(DEPTH - 1));
  assign o_overflow  = ovf_q;

  // Survivors (after pop and partial-flush filtering) plus an accepted push are packed from entry 0.
  always_comb begin : next_state
    logic [CW-1:0]    k;
    logic [TAG_W-1:0] flush_age;
    logic             full;
    ovf_set   = 1'b0;
    flush_age = age(i_flush_tag, i_rob_head_tag);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_d[s][i] = '0;
        val_d[s][i] = '0;
      end
      k    = '0;
      full = (cnt_q[s] == CW'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
        if ((i < int'(cnt_q[s])) && !(pop[s] && (i == 0)) &&
            (!i_flush_en || (age(tag_q[s][i], i_rob_head_tag) <= flush_age))) begin
          tag_d[s][k[IW-1:0]] = tag_q[s][i];
          val_d[s][k[IW-1:0]] = val_q[s][i];
          k = k + CW'(1);
        end
      end
      if (in_v[s] && full && !pop[s] && !i_flush) begin
        ovf_set = 1'b1;
      end
      if (in_v[s] && (!full || pop[s]) &&
          (!i_flush_en || (age(in_tag[s], i_rob_head_tag) <= flush_age))) begin
        tag_d[s][k[IW-1:0]] = in_tag[s];
        val_d[s][k[IW-1:0]] = in_val[s];
        k = k + CW'(1);
      end
      cnt_d[s] = i_flush ? '0 : k;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          tag_q[s][i] <= '0;
          val_q[s][i] <= '0;
        end
      end
      ovf_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= cnt_d[s];
        for (int i = 0; i < DEPTH; i++) begin
          tag_q[s][i] <= tag_d[s][i];
          val_q[s][i] <= val_d[s][i];
        end
      end
      ovf_q <= ovf_q | ovf_set;
    end
  end

endmodule

// File: tb/tb_muldiv_cdb_arbiter.sv
// Scoreboard bench for muldiv_cdb_arbiter: stimulus queues expected CDB results,
// and a negedge monitor checks each granted result in order.
module tb_muldiv_cdb_arbiter;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mul_valid, div_valid;
  logic [TAG_W-1:0] mul_tag, div_tag;
  logic [XLEN-1:0]  mul_value, div_value;
  logic             mul_stall, div_stall;
  logic             cdb_valid, cdb_is_div;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             grant, flush, flush_en;
  logic [TAG_W-1:0] flush_tag, head;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  logic [TAG_W+XLEN:0] sb [$];

  muldiv_cdb_arbiter #(.TAG_W(TAG_W), .XLEN(XLEN), .DEPTH(2)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mul_valid    (mul_valid),
    .i_mul_tag      (mul_tag),
    .i_mul_value    (mul_value),
    .i_div_valid    (div_valid),
    .i_div_tag      (div_tag),
    .i_div_value    (div_value),
    .o_mul_stall    (mul_stall),
    .o_div_stall    (div_stall),
    .o_cdb_valid    (cdb_valid),
    .o_cdb_tag      (cdb_tag),
    .o_cdb_value    (cdb_value),
    .o_cdb_is_div   (cdb_is_div),
    .i_cdb_grant    (grant),
    .i_flush        (flush),
    .i_flush_en     (flush_en),
    .i_flush_tag    (flush_tag),
    .i_rob_head_tag (head),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  // A granted presentation is consumed at the next posedge, so it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && cdb_valid && grant && !flush) begin
      logic [TAG_W+XLEN:0] exp_e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got div=%0b tag=%0d value=%0h, required no result",
                 cdb_is_div, cdb_tag, cdb_value);
      end else begin
        exp_e = sb.pop_front();
        if ({cdb_is_div, cdb_tag, cdb_value} !== exp_e) begin
          errors++;
          $display("FAIL cdb_result: got div=%0b tag=%0d value=%0h, required div=%0b tag=%0d value=%0h",
                   cdb_is_div, cdb_tag, cdb_value, exp_e[TAG_W+XLEN],
                   exp_e[TAG_W+XLEN-1:XLEN], exp_e[XLEN-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_res(input logic is_div, input logic [TAG_W-1:0] tag,
                            input logic [XLEN-1:0] val);
    sb.push_back({is_div, tag, val});
  endtask

  task automatic set_mul(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    mul_valid = 1'b1;
    mul_tag   = tag;
    mul_value = val;
  endtask

  task automatic set_div(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    div_valid = 1'b1;
    div_tag   = tag;
    div_value = val;
  endtask

  task automatic clear_in();
    mul_valid = 1'b0;
    div_valid = 1'b0;
    flush     = 1'b0;
    flush_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    mul_tag = '0; mul_value = '0; div_tag = '0; div_value = '0;
    grant = 1'b0; flush_tag = '0; head = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    check("reset_valid",    32'(cdb_valid),  32'd0);
    check("reset_tag",      32'(cdb_tag),    32'd0);
    check("reset_value",    cdb_value,       32'd0);
    check("reset_is_div",   32'(cdb_is_div), 32'd0);
    check("reset_mul_stall", 32'(mul_stall), 32'd0);
    check("reset_div_stall", 32'(div_stall), 32'd0);
    check("reset_overflow", 32'(overflow),   32'd0);

    // Single MUL result, grant held high.
    grant = 1'b1;
    set_mul(5'd3, 32'h0000_0042);
    expect_res(1'b0, 5'd3, 32'h0000_0042);
    step();
    clear_in();
    check("single_latency_valid", 32'(cdb_valid), 32'd1);
    step();
    check("single_drained", 32'(cdb_valid), 32'd0);

    // Age order: head=4, DIV tag 5 (age 1) before MUL tag 7 (age 3).
    grant = 1'b0;
    head  = 5'd4;
    set_mul(5'd7, 32'h7777);
    set_div(5'd5, 32'h5555);
    expect_res(1'b1, 5'd5, 32'h5555);
    expect_res(1'b0, 5'd7, 32'h7777);
    step();
    clear_in();
    grant = 1'b1;
    step();
    step();
    grant = 1'b0;
    check("age_drained", 32'(cdb_valid), 32'd0);

    // Wrap: head=30, MUL tag 1 (age 3) vs DIV tag 31 (age 1).
    head = 5'd30;
    set_mul(5'd1, 32'h1111);
    set_div(5'd31, 32'h3131);
    expect_res(1'b1, 5'd31, 32'h3131);
    expect_res(1'b0, 5'd1, 32'h1111);
    step();
    clear_in();
    grant = 1'b1;
    step();
    step();
    grant = 1'b0;
    check("wrap_drained", 32'(cdb_valid), 32'd0);

    // Stall and overflow with grant low.
    head = 5'd0;
    set_mul(5'd10, 32'hA0A0);
    step();
    check("stall_after_one", 32'(mul_stall), 32'd1);
    check("no_overflow_yet", 32'(overflow), 32'd0);
    set_mul(5'd11, 32'hB1B1);
    step();
    set_mul(5'd12, 32'hC2C2);
    step();
    clear_in();
    check("overflow_set", 32'(overflow), 32'd1);
    expect_res(1'b0, 5'd10, 32'hA0A0);
    expect_res(1'b0, 5'd11, 32'hB1B1);
    grant = 1'b1;
    step();
    step();
    grant = 1'b0;
    check("overflow_two_kept", 32'(cdb_valid), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Partial flush at tag 5: drop 6 and 9, keep 2, accept incoming 4.
    set_mul(5'd2, 32'h0202);
    step();
    set_mul(5'd6, 32'h0606);
    set_div(5'd9, 32'h0909);
    step();
    clear_in();
    set_div(5'd4, 32'h0404);
    flush_en  = 1'b1;
    flush_tag = 5'd5;
    step();
    clear_in();
    check("pflush_mul_stall", 32'(mul_stall), 32'd1);
    expect_res(1'b0, 5'd2, 32'h0202);
    expect_res(1'b1, 5'd4, 32'h0404);
    grant = 1'b1;
    step();
    step();
    grant = 1'b0;
    check("pflush_drained", 32'(cdb_valid), 32'd0);

    // Full flush with both queues occupied and a same-cycle push.
    set_mul(5'd3, 32'h0303);
    set_div(5'd8, 32'h0808);
    step();
    clear_in();
    set_mul(5'd5, 32'h0505);
    flush = 1'b1;
    step();
    clear_in();
    check("flush_valid",     32'(cdb_valid), 32'd0);
    check("flush_mul_stall", 32'(mul_stall), 32'd0);
    check("flush_div_stall", 32'(div_stall), 32'd0);
    grant = 1'b1;
    set_mul(5'd1, 32'h0101);
    expect_res(1'b0, 5'd1, 32'h0101);
    step();
    clear_in();
    step();
    grant = 1'b0;
    check("post_flush_drained", 32'(cdb_valid), 32'd0);

    // Asynchronous reset mid-cycle with entries queued.
    set_mul(5'd4, 32'h0404);
    set_div(5'd6, 32'h0606);
    step();
    clear_in();
    check("prereset_valid", 32'(cdb_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid",     32'(cdb_valid), 32'd0);
    check("areset_tag",       32'(cdb_tag),   32'd0);
    check("areset_value",     cdb_value,      32'd0);
    check("areset_mul_stall", 32'(mul_stall), 32'd0);
    check("areset_div_stall", 32'(div_stall), 32'd0);
    check("areset_overflow",  32'(overflow),  32'd0);
    #3 rst_n = 1'b1;
    step();
    check("after_reset_valid", 32'(cdb_valid), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
